mac_row_collector: RTL and testbench
====================================

# mac_row_collector

Result-side receiver for the 4-array MAC pipeline: consumes the final-stage 4×4 result tile on each valid beat, reduces each tile row to a scalar, and accumulates those scalars across the k-steps of one row block. When a block completes it emits four per-row dot-product results, one per cycle, on a valid/ready stream to the writeback path. It sits directly behind the last array's result port and replaces software-side row summation.

## Interface
- TILE_SIZE, 4, tile edge; rows per block and columns per row-sum
- ACC_WIDTH, 32, signed width of each incoming tile element
- OUT_WIDTH, 48, signed width of row accumulators and output data
- IDX_WIDTH, 16, width of output row index
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- clr  in  1  synchronous pulse: flush pipeline, accumulators, drain buffer, counters, error flag
- cfg_beats  in  8  valid beats per row block; 0 treated as 1
- res_valid  in  1  result tile valid (driven by pipeline valid_out); no backpressure
- res_tile  in  TILE_SIZE×TILE_SIZE×ACC_WIDTH  signed result tile, [row][col]
- row_valid  out  1  output row result valid
- row_ready  in  1  downstream accepts when row_valid & row_ready
- row_idx  out  IDX_WIDTH  global row index of row_data
- row_data  out  OUT_WIDTH  signed accumulated row result
- blk_done  out  1  one-cycle pulse when a completed block is loaded into the drain buffer
- ovf_err  out  1  sticky: a completed block was dropped because the drain buffer was busy

## Operation
- Stage 1 (reduce): on res_valid, each row's TILE_SIZE elements sign-extended to OUT_WIDTH and summed; sums and a beat-valid bit registered.
- Stage 2 (accumulate): on registered beat-valid, acc[i] += sum[i]; beat counter increments. cfg_beats captured when beat counter is 0 and the first beat of a block arrives; changes mid-block ignored.
- Block completion: on the beat where count reaches captured cfg_beats, acc[i] + sum[i] is written to drain buffer (not acc), acc cleared, counter reset to 0, blk_done pulses, block counter increments. A beat in the following cycle starts the next block cleanly.
- Drain FSM states: IDLE, DRAIN. IDLE→DRAIN on buffer load. In DRAIN, row_valid=1, row_data=buf[ptr], row_idx=blk_base+ptr, blk_base=block_count×TILE_SIZE (wraps at 2^IDX_WIDTH). Handshake advances ptr; after ptr=TILE_SIZE−1 accepted → IDLE.
- Drain buffer busy (DRAIN, not accepting last row that cycle) at block completion: new block discarded, ovf_err set, block counter still increments (indices stay aligned). Completion on the same cycle the last row is accepted is not an overflow: buffer reloads, FSM stays in DRAIN, ptr=0.
- row_data/row_idx held stable while row_valid & !row_ready.
- Arithmetic wraps at OUT_WIDTH (two's complement) unless saturation configured.

## Timing
- Reset/clr values: row_valid=0, row_idx=0, row_data=0, blk_done=0, ovf_err=0; acc, counters, ptr=0, FSM IDLE. clr has priority over every same-cycle event including a final beat.
- Beat sampled at edge E → accumulated at edge E+1. Final beat at edge E → blk_done and row_valid high in cycle after E+1; first row accepted no earlier than edge E+2.
- Throughput: one tile per cycle input, indefinitely; output one row per cycle with row_ready held high, so a block drains in TILE_SIZE cycles; cfg_beats ≥ TILE_SIZE guarantees no overflow with row_ready=1.
- res_valid gaps of any length allowed mid-block; state preserved.

## Configuration
- MAC_ROW_COLLECTOR_SAT_EN defined: row-sum and accumulate results clamp to [−2^(OUT_WIDTH−1), 2^(OUT_WIDTH−1)−1]; saturation is per-addition, sticky in value only (no flag).
- Not defined: plain wrapping addition; no clamp logic synthesized.

## Structure
- Shared package mac_pkg: TILE_SIZE/ACC_WIDTH defaults, tile element typedef, drain FSM state enum, saturating-add function (guarded by macro).
- One sub-module: mac_row_reduce (combinational/registered TILE_SIZE-input sign-extending adder, stage 1), instantiated once per row.

## Test plan
- cfg_beats=1, tile all 1 → after 2 cycles rows 0..3 output data=4, idx 0,1,2,3, blk_done pulse once.
- cfg_beats=19, ten blocks back-to-back, tile row i elements = i−2 → each row data=19×4×(i−2); idx 0..39 in order, ovf_err=0.
- cfg_beats=2, row_ready=0 for 10 cycles → first block held stable; second completion sets ovf_err, dropped; third block idx base=8.
- res_valid gaps (beat, 3 idle, beat) with cfg_beats=2 → identical result to contiguous beats.
- Elements 0x7FFFFFFF, OUT_WIDTH=34, cfg_beats=4 → with SAT_EN data=2^33−1; without, wrapped value.
- clr asserted coincident with final beat → no blk_done, no row_valid, next block starts at idx 0.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and helpers for the MAC result-side collector (mac_row_collector).
// Pure declarations: no state, no latency, no flow control.
// MAC_ROW_COLLECTOR_SAT_EN adds the saturating adder used in place of wrapping adds.
package mac_pkg;

  localparam int MAC_TILE_SIZE = 4;
  localparam int MAC_ACC_WIDTH = 32;
  // Widest accumulator the saturating helper can clamp (OUT_WIDTH must be below this).
  localparam int SAT_MAXW      = 64;

  typedef logic signed [MAC_ACC_WIDTH-1:0] mac_elem_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } drain_state_t;

`ifdef MAC_ROW_COLLECTOR_SAT_EN
  // Adds two values already sign-extended from width w and clamps to the signed w-bit range.
  function automatic logic signed [SAT_MAXW-1:0] sat_add(
    input logic signed [SAT_MAXW-1:0] a,
    input logic signed [SAT_MAXW-1:0] b,
    input int                         w
  );
    logic signed [SAT_MAXW:0] s;
    logic signed [SAT_MAXW:0] one;
    logic signed [SAT_MAXW:0] hi;
    logic signed [SAT_MAXW:0] lo;
    one    = '0;
    one[0] = 1'b1;
    s      = {a[SAT_MAXW-1], a} + {b[SAT_MAXW-1], b};
    hi     = (one <<< (w - 1)) - one;
    lo     = -(one <<< (w - 1));
    if (s > hi)      return hi[SAT_MAXW-1:0];
    else if (s < lo) return lo[SAT_MAXW-1:0];
    else             return s[SAT_MAXW-1:0];
  endfunction
`endif

endpackage

// File: rtl/mac_row_reduce.sv
// Stage 1: sign-extends one tile row and sums its elements into an OUT_WIDTH scalar.
// Latency 1 cycle (sum registered on in_valid, held otherwise).
// No backpressure; clamps per addition when MAC_ROW_COLLECTOR_SAT_EN is defined.
module mac_row_reduce
  import mac_pkg::*;
#(
  parameter int TILE_SIZE = MAC_TILE_SIZE,
  parameter int ACC_WIDTH = MAC_ACC_WIDTH,
  parameter int OUT_WIDTH = 48
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clr,
  input  logic                           in_valid,
  input  logic [TILE_SIZE*ACC_WIDTH-1:0] row_in,
  output logic signed [OUT_WIDTH-1:0]    sum
);

  function automatic logic signed [OUT_WIDTH-1:0] add_ow(
    input logic signed [OUT_WIDTH-1:0] a,
    input logic signed [OUT_WIDTH-1:0] b
  );
`ifdef MAC_ROW_COLLECTOR_SAT_EN
    logic signed [SAT_MAXW-1:0] r;
    r = sat_add(SAT_MAXW'(a), SAT_MAXW'(b), OUT_WIDTH);
    return r[OUT_WIDTH-1:0];
`else
    return a + b;
`endif
  endfunction

  logic signed [OUT_WIDTH-1:0] sum_c;

  // Chain of additions across the row, each element sign-extended first.
  always_comb begin
    sum_c = '0;
    for (int c = 0; c < TILE_SIZE; c++) begin
      sum_c = add_ow(sum_c, OUT_WIDTH'($signed(row_in[c*ACC_WIDTH +: ACC_WIDTH])));
    end
  end

  // Capture the row sum only on a valid beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        sum <= '0;
    else if (clr)      sum <= '0;
    else if (in_valid) sum <= sum_c;
  end

endmodule

// File: rtl/mac_row_collector.sv
// Reduces each result-tile row, accumulates over a block, then streams TILE_SIZE row results.
// Latency: final beat sampled at edge E -> row_valid/blk_done high after edge E+1.
// Input has no backpressure; a block completing while the drain buffer is busy is dropped (ovf_err).
// Optional: MAC_ROW_COLLECTOR_SAT_EN selects saturating instead of wrapping arithmetic.
module mac_row_collector
  import mac_pkg::*;
#(
  parameter int TILE_SIZE = MAC_TILE_SIZE,
  parameter int ACC_WIDTH = MAC_ACC_WIDTH,
  parameter int OUT_WIDTH = 48,
  parameter int IDX_WIDTH = 16
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     clr,
  input  logic [7:0]                               cfg_beats,
  input  logic                                     res_valid,
  input  logic [TILE_SIZE*TILE_SIZE*ACC_WIDTH-1:0] res_tile,
  output logic                                     row_valid,
  input  logic                                     row_ready,
  output logic [IDX_WIDTH-1:0]                     row_idx,
  output logic [OUT_WIDTH-1:0]                     row_data,
  output logic                                     blk_done,
  output logic                                     ovf_err
);

  localparam int PTR_W = (TILE_SIZE > 1) ? $clog2(TILE_SIZE) : 1;
  localparam int ROW_W = TILE_SIZE * ACC_WIDTH;

  function automatic logic signed [OUT_WIDTH-1:0] add_ow(
    input logic signed [OUT_WIDTH-1:0] a,
    input logic signed [OUT_WIDTH-1:0] b
  );
`ifdef MAC_ROW_COLLECTOR_SAT_EN
    logic signed [SAT_MAXW-1:0] r;
    r = sat_add(SAT_MAXW'(a), SAT_MAXW'(b), OUT_WIDTH);
    return r[OUT_WIDTH-1:0];
`else
    return a + b;
`endif
  endfunction

  logic signed [OUT_WIDTH-1:0] row_sum   [TILE_SIZE];
  logic signed [OUT_WIDTH-1:0] acc       [TILE_SIZE];
  logic signed [OUT_WIDTH-1:0] drain_buf [TILE_SIZE];
  logic                        beat_vld;
  logic [7:0]                  beat_cnt;
  logic [7:0]                  beats_cap;
  logic [7:0]                  eff_beats;
  logic                        last_beat;
  logic                        last_take;
  logic                        buf_busy;
  logic                        buf_load;
  logic [IDX_WIDTH-1:0]        next_base;
  logic [IDX_WIDTH-1:0]        buf_base;
  logic [PTR_W-1:0]            ptr;
  drain_state_t                state;
  drain_state_t                state_n;

  for (genvar r = 0; r < TILE_SIZE; r++) begin : g_row
    mac_row_reduce #(
      .TILE_SIZE (TILE_SIZE),
      .ACC_WIDTH (ACC_WIDTH),
      .OUT_WIDTH (OUT_WIDTH)
    ) u_reduce (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .in_valid (res_valid),
      .row_in   (res_tile[r*ROW_W +: ROW_W]),
      .sum      (row_sum[r])
    );
  end

  // Stage-1 valid bit travels alongside the registered row sums.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   beat_vld <= 1'b0;
    else if (clr) beat_vld <= 1'b0;
    else          beat_vld <= res_valid;
  end

  // Block length: live cfg on the first beat of a block (0 means 1), captured copy afterwards.
  always_comb begin
    eff_beats = beats_cap;
    if (beat_cnt == 8'd0) eff_beats = (cfg_beats == 8'd0) ? 8'd1 : cfg_beats;
  end

  assign last_beat = beat_vld && (({1'b0, beat_cnt} + 9'd1) == {1'b0, eff_beats});
  assign last_take = (state == ST_DRAIN) && row_ready && (ptr == PTR_W'(TILE_SIZE - 1));
  assign buf_busy  = (state == ST_DRAIN) && !last_take;
  assign buf_load  = last_beat && !buf_busy;

  // Stage 2: accumulate row sums; the final beat bypasses acc straight into the drain buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TILE_SIZE; i++) acc[i] <= '0;
      beat_cnt  <= '0;
      beats_cap <= '0;
    end else if (clr) begin
      for (int i = 0; i < TILE_SIZE; i++) acc[i] <= '0;
      beat_cnt  <= '0;
      beats_cap <= '0;
    end else if (beat_vld) begin
      if (beat_cnt == 8'd0) beats_cap <= eff_beats;
      if (last_beat) begin
        for (int i = 0; i < TILE_SIZE; i++) acc[i] <= '0;
        beat_cnt <= '0;
      end else begin
        for (int i = 0; i < TILE_SIZE; i++) acc[i] <= add_ow(acc[i], row_sum[i]);
        beat_cnt <= beat_cnt + 8'd1;
      end
    end
  end

  // Drain buffer, row pointer, block indexing and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TILE_SIZE; i++) drain_buf[i] <= '0;
      next_base <= '0;
      buf_base  <= '0;
      ptr       <= '0;
      blk_done  <= 1'b0;
      ovf_err   <= 1'b0;
    end else if (clr) begin
      for (int i = 0; i < TILE_SIZE; i++) drain_buf[i] <= '0;
      next_base <= '0;
      buf_base  <= '0;
      ptr       <= '0;
      blk_done  <= 1'b0;
      ovf_err   <= 1'b0;
    end else begin
      blk_done <= buf_load;
      // Dropped blocks still consume an index range so later blocks stay aligned.
      if (last_beat) next_base <= next_base + IDX_WIDTH'(TILE_SIZE);
      if (last_beat && buf_busy) ovf_err <= 1'b1;
      if (buf_load) begin
        for (int i = 0; i < TILE_SIZE; i++) drain_buf[i] <= add_ow(acc[i], row_sum[i]);
        buf_base <= next_base;
        ptr      <= '0;
      end else if ((state == ST_DRAIN) && row_ready) begin
        ptr <= ptr + PTR_W'(1);
      end
    end
  end

  // Drain FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  // Drain FSM next state and output stream; outputs read zero while idle.
  always_comb begin
    state_n   = state;
    row_valid = 1'b0;
    row_data  = '0;
    row_idx   = '0;
    if (clr) begin
      state_n = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (buf_load)  state_n = ST_DRAIN;
        ST_DRAIN: if (last_take) state_n = buf_load ? ST_DRAIN : ST_IDLE;
        default:  state_n = ST_IDLE;
      endcase
    end
    if (state == ST_DRAIN) begin
      row_valid = 1'b1;
      row_data  = drain_buf[ptr];
      row_idx   = buf_base + IDX_WIDTH'(ptr);
    end
  end

endmodule

// File: tb/tb_mac_row_collector.sv
// Directed bench for mac_row_collector (OUT_WIDTH=34 so the saturation case is reachable).
// Expected rows are queued before each block's beats; a negedge monitor pops and compares them.
// Honours MAC_ROW_COLLECTOR_SAT_EN for the clamping vector.
module tb_mac_row_collector;

  localparam int TS = 4;
  localparam int AW = 32;
  localparam int OW = 34;
  localparam int IW = 16;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  clr = 1'b0;
  logic [7:0]            cfg_beats = 8'd1;
  logic                  res_valid = 1'b0;
  logic [TS*TS*AW-1:0]   res_tile = '0;
  logic                  row_valid;
  logic                  row_ready = 1'b1;
  logic [IW-1:0]         row_idx;
  logic [OW-1:0]         row_data;
  logic                  blk_done;
  logic                  ovf_err;

  typedef struct {
    logic [IW-1:0] idx;
    logic [OW-1:0] data;
  } exp_t;

  typedef struct {
    int cfg; int cfg_after; int nbeats; int gap;
    int v0; int v1; int v2; int v3;
    longint e0; longint e1; longint e2; longint e3;
  } vec_t;

  exp_t          sb[$];
  exp_t          e;
  int            checks = 0;
  int            errs = 0;
  int            done_cnt = 0;
  int            nblk = 0;
  logic          prev_hold = 1'b0;
  logic [IW-1:0] prev_idx;
  logic [OW-1:0] prev_data;

  mac_row_collector #(
    .TILE_SIZE (TS),
    .ACC_WIDTH (AW),
    .OUT_WIDTH (OW),
    .IDX_WIDTH (IW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .cfg_beats (cfg_beats),
    .res_valid (res_valid),
    .res_tile  (res_tile),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .row_idx   (row_idx),
    .row_data  (row_data),
    .blk_done  (blk_done),
    .ovf_err   (ovf_err)
  );

  always #5 clk = ~clk;

  // Output monitor: scoreboard compare on handshakes, hold-stability while stalled.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (blk_done) done_cnt++;
      if (prev_hold) begin
        checks++;
        if (!row_valid || row_idx !== prev_idx || row_data !== prev_data) begin
          errs++;
          $display("FAIL hold: got valid=%0b idx=%0d data=%0h, expected valid=1 idx=%0d data=%0h",
                   row_valid, row_idx, row_data, prev_idx, prev_data);
        end
      end
      if (row_valid && row_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errs++;
          $display("FAIL row: unexpected row idx=%0d data=%0h, none expected", row_idx, row_data);
        end else begin
          e = sb.pop_front();
          if (row_idx !== e.idx || row_data !== e.data) begin
            errs++;
            $display("FAIL row: got idx=%0d data=%0h expected idx=%0d data=%0h",
                     row_idx, row_data, e.idx, e.data);
          end
        end
      end
      prev_hold = row_valid && !row_ready;
      prev_idx  = row_idx;
      prev_data = row_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic beat(input int v0, input int v1, input int v2, input int v3);
    int vv[TS];
    vv = '{v0, v1, v2, v3};
    for (int r = 0; r < TS; r++)
      for (int c = 0; c < TS; c++)
        res_tile[(r*TS+c)*AW +: AW] = vv[r];
    res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
  endtask

  task automatic push_blk(input longint d0, input longint d1, input longint d2, input longint d3);
    longint dd[TS];
    exp_t   x;
    dd = '{d0, d1, d2, d3};
    for (int i = 0; i < TS; i++) begin
      x.idx  = IW'(nblk * TS + i);
      x.data = OW'(dd[i]);
      sb.push_back(x);
    end
    nblk++;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || row_valid) && n < 400) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 400) begin
      errs++;
      $display("FAIL %s: drain timeout, got %0d rows outstanding expected 0", name, sb.size());
    end
    tick();
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    nblk = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[6];
    int   d0;
    longint sat_exp;

    tbl[0] = '{1, 1, 1, 0,     1,       1, 1,      1,        4,        4,   4,       4};
    tbl[1] = '{0, 0, 1, 0,     1,       2, 3,      4,        4,        8,  12,      16};
    tbl[2] = '{2, 2, 2, 3,     5,      -1, 0,      7,       40,       -8,   0,      56};
    tbl[3] = '{2, 2, 2, 0,     5,      -1, 0,      7,       40,       -8,   0,      56};
    tbl[4] = '{3, 1, 3, 1,  -100,    1000, -7, 123456,   -1200,    12000, -84, 1481472};
    tbl[5] = '{5, 5, 5, 0, -1000000,    2, 0,     -1, -20000000,      40,   0,     -20};

    // Reset state
    #3;
    chk("rst row_valid", row_valid, 0);
    chk("rst row_idx",   row_idx,   0);
    chk("rst row_data",  row_data,  0);
    chk("rst blk_done",  blk_done,  0);
    chk("rst ovf_err",   ovf_err,   0);
    #20;
    rst_n = 1'b1;
    tick();

    // Table-driven blocks with ready held high
    for (int k = 0; k < 6; k++) begin
      d0 = done_cnt;
      cfg_beats = 8'(tbl[k].cfg);
      push_blk(tbl[k].e0, tbl[k].e1, tbl[k].e2, tbl[k].e3);
      for (int b = 0; b < tbl[k].nbeats; b++) begin
        beat(tbl[k].v0, tbl[k].v1, tbl[k].v2, tbl[k].v3);
        if (b == 1) cfg_beats = 8'(tbl[k].cfg_after);
        if (b < tbl[k].nbeats - 1) repeat (tbl[k].gap) tick();
      end
      wait_idle($sformatf("vec%0d", k));
      chk($sformatf("vec%0d blk_done pulses", k), done_cnt - d0, 1);
    end
    chk("table ovf_err", ovf_err, 0);

    // Ten back-to-back 19-beat blocks from index 0
    do_clr();
    cfg_beats = 8'd19;
    for (int k = 0; k < 10; k++) push_blk(-152, -76, 0, 76);
    for (int b = 0; b < 190; b++) beat(-2, -1, 0, 1);
    wait_idle("stream");
    chk("stream ovf_err", ovf_err, 0);

    // Accumulation overflow: clamp or wrap at 34 bits
`ifdef MAC_ROW_COLLECTOR_SAT_EN
    sat_exp = 64'sd8589934591;
`else
    sat_exp = -64'sd16;
`endif
    cfg_beats = 8'd4;
    push_blk(sat_exp, sat_exp, sat_exp, sat_exp);
    for (int b = 0; b < 4; b++) beat(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF);
    wait_idle("sat");

    // Stalled drain: second block dropped, third lands at index base 8
    do_clr();
    chk("clr ovf_err", ovf_err, 0);
    cfg_beats = 8'd2;
    row_ready = 1'b0;
    push_blk(8, 16, 24, 32);
    nblk++;
    for (int b = 0; b < 4; b++) beat(1, 2, 3, 4);
    repeat (6) tick();
    chk("stall ovf_err",   ovf_err,   1);
    chk("stall row_valid", row_valid, 1);
    chk("stall row_idx",   row_idx,   0);
    chk("stall row_data",  row_data,  8);
    row_ready = 1'b1;
    wait_idle("stall drain A");
    push_blk(-8, -16, -24, -32);
    for (int b = 0; b < 2; b++) beat(-1, -2, -3, -4);
    wait_idle("stall block C");
    chk("ovf_err sticky", ovf_err, 1);

    // clr on the cycle the final beat is accumulated
    do_clr();
    chk("clr2 ovf_err", ovf_err, 0);
    d0 = done_cnt;
    cfg_beats = 8'd2;
    beat(9, 9, 9, 9);
    beat(9, 9, 9, 9);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (4) tick();
    chk("clr final blk_done", done_cnt - d0, 0);
    chk("clr final row_valid", row_valid, 0);
    cfg_beats = 8'd1;
    push_blk(12, 12, 12, 12);
    beat(3, 3, 3, 3);
    wait_idle("after clr");
    chk("after clr blk_done", done_cnt - d0, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
